// File: rtl/game_scene_render_pkg.sv
// Shared definitions for the game scene renderer.
// Holds the RGB565 palette, the descriptor width function and the
// descriptor field offsets. Descriptor layout, MSB to LSB:
//   {x0, x1, y0, y1, colour[15:0], enable, blink}
package game_scene_pkg;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BROWN   = 16'hA145;
    localparam logic [15:0] SKYBLUE = 16'h867D;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    localparam int COLOUR_W   = 16;
    localparam int OFF_BLINK  = 0;
    localparam int OFF_EN     = 1;
    localparam int OFF_COLOUR = 2;
    localparam int OFF_Y1     = OFF_COLOUR + COLOUR_W;

    function automatic int rect_w(input int xw, input int yw);
        return 2 * xw + 2 * yw + 18;
    endfunction

    function automatic int off_y0(input int yw);
        return OFF_Y1 + yw;
    endfunction

    function automatic int off_x1(input int yw);
        return OFF_Y1 + 2 * yw;
    endfunction

    function automatic int off_x0(input int xw, input int yw);
        return OFF_Y1 + 2 * yw + xw;
    endfunction

endpackage

// File: rtl/game_scene_render_if.sv
// Rectangle-table write bus.
//   wr_en   - write strobe
//   wr_idx  - slot index (indices beyond the table are ignored)
//   wr_data - rectangle descriptor
// master drives the bus, slave (the renderer) receives it.
interface game_scene_render_if #(
    parameter int RECT_W = 44
);
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [RECT_W-1:0] wr_data;

    modport master (output wr_en, wr_idx, wr_data);
    modport slave  (input  wr_en, wr_idx, wr_data);
endinterface

// File: rtl/game_scene_render_rect_hit.sv
// Combinational hit test for one rectangle slot.
//   desc        - slot descriptor
//   x, y        - current pixel
//   blink_phase - global blink phase; blinking slots hide when it is 1
//   hit         - pixel lies inside an enabled, visible rectangle
// Bounds are inclusive and unsigned, so x0>x1 or y0>y1 can never hit.
module rect_hit
    import game_scene_pkg::*;
#(
    parameter int X_W = 7,
    parameter int Y_W = 6
) (
    input  logic [rect_w(X_W, Y_W)-1:0] desc,
    input  logic [X_W-1:0]              x,
    input  logic [Y_W-1:0]              y,
    input  logic                        blink_phase,
    output logic                        hit
);
    localparam int OX0 = off_x0(X_W, Y_W);
    localparam int OX1 = off_x1(Y_W);
    localparam int OY0 = off_y0(Y_W);

    logic [X_W-1:0] x0, x1;
    logic [Y_W-1:0] y0, y1;
    logic           unused_colour;

    assign x0 = desc[OX0 +: X_W];
    assign x1 = desc[OX1 +: X_W];
    assign y0 = desc[OY0 +: Y_W];
    assign y1 = desc[OFF_Y1 +: Y_W];

    // Colour is selected by the priority mux in the top.
    assign unused_colour = ^desc[OFF_COLOUR +: COLOUR_W];

    assign hit = desc[OFF_EN]
               && (x0 <= x) && (x <= x1)
               && (y0 <= y) && (y <= y1)
               && !(desc[OFF_BLINK] && blink_phase);
endmodule

// File: rtl/game_scene_render.sv
// Rectangle-list scene renderer for a small RGB565 OLED.
//   clk, reset         - clock and synchronous active-high reset
//   x, y               - pixel currently requested by the OLED driver
//   frame_tick         - one pulse per completed frame, drives blinking
//   active             - enables background flashing in the blink phase
//   wr_bus (slave)     - rectangle-table write port
//   oled_data          - registered pixel colour, one cycle after x/y
// The highest-index hitting slot wins; with no hit the background is shown.
module game_scene_render
    import game_scene_pkg::*;
#(
    parameter int          NUM_RECTS    = 8,
    parameter int          X_W          = 7,
    parameter int          Y_W          = 6,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [15:0] BG_COLOUR    = 16'hFFFF,
    parameter logic [15:0] FLASH_COLOUR = 16'hF81F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [X_W-1:0]       x,
    input  logic [Y_W-1:0]       y,
    input  logic                 frame_tick,
    input  logic                 active,
    game_scene_render_if.slave   wr_bus,
    output logic [15:0]          oled_data
);
    localparam int                RECT_W   = rect_w(X_W, Y_W);
    localparam int                CNT_W    = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [RECT_W-1:0]    slots_q [NUM_RECTS];
    logic [CNT_W-1:0]     frame_cnt;
    logic                 blink_phase;
    logic [NUM_RECTS-1:0] hit;
    logic [15:0]          pixel;

    // Slot table. A slot is only written when wr_idx matches its own index,
    // so out-of-range indices fall through without touching anything.
    // NOTE: the table is reset explicitly because a cleared table (all slots
    // disabled) is part of the reset state, not just the control logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_RECTS; k++) slots_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_RECTS; k++) begin
                if (wr_bus.wr_en && (wr_bus.wr_idx == 4'(k)))
                    slots_q[k] <= wr_bus.wr_data;
            end
        end
    end

    // Blink timing runs independently of active; active only gates the
    // background flash.
    // NOTE: non-blocking assignments keep every register update in this
    // block reading pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_RECTS; k++) begin : g_hit
        rect_hit #(.X_W(X_W), .Y_W(Y_W)) u_rect_hit (
            .desc        (slots_q[k]),
            .x           (x),
            .y           (y),
            .blink_phase (blink_phase),
            .hit         (hit[k])
        );
    end

    // Ascending scan: later (higher-index) hits overwrite earlier ones.
    // NOTE: pixel gets its default before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        pixel = (active && blink_phase) ? FLASH_COLOUR : BG_COLOUR;
        for (int k = 0; k < NUM_RECTS; k++) begin
            if (hit[k]) pixel = slots_q[k][OFF_COLOUR +: COLOUR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) oled_data <= BG_COLOUR;
        else       oled_data <= pixel;
    end
endmodule

// File: tb/tb_game_scene_render.sv
// Self-checking bench for game_scene_render (BLINK_FRAMES=2 so blink
// phases are reachable in a few ticks). A behavioural model keeps the slot
// table as plain fields and derives the blink phase from the number of
// frame ticks since reset.
module tb_game_scene_render;
    import game_scene_pkg::*;

    localparam int          NR     = 8;
    localparam int          BF     = 2;
    localparam int          RW     = 44;
    localparam logic [15:0] BG     = 16'hFFFF;
    localparam logic [15:0] FLASH  = 16'hF81F;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        frame_tick;
    logic        active;
    logic [15:0] oled_data;

    game_scene_render_if #(.RECT_W(RW)) wr_bus ();

    game_scene_render #(
        .NUM_RECTS    (NR),
        .X_W          (7),
        .Y_W          (6),
        .BLINK_FRAMES (BF),
        .BG_COLOUR    (BG),
        .FLASH_COLOUR (FLASH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .active     (active),
        .wr_bus     (wr_bus.slave),
        .oled_data  (oled_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x0, x1, y0, y1;
        logic [15:0] colour;
        bit          en, blink;
    } rect_t;

    typedef struct {
        string       name;
        int          px, py;
        bit          act;
        logic [15:0] exp;
    } vec_t;

    rect_t m [NR];
    int    ticks;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: oled_data=%h expected=%h", name, got, exp);
    endtask

    function automatic logic [RW-1:0] pack(input int x0, x1, y0, y1,
                                            input logic [15:0] c, input bit en, bl);
        logic [6:0] a0, a1;
        logic [5:0] b0, b1;
        a0 = 7'(x0); a1 = 7'(x1); b0 = 6'(y0); b1 = 6'(y1);
        return {a0, a1, b0, b1, c, en, bl};
    endfunction

    function automatic logic [15:0] model_pixel(input int px, py, input bit act);
        bit phase;
        phase = ((ticks / BF) % 2) == 1;
        for (int k = NR - 1; k >= 0; k--) begin
            if (m[k].en && m[k].x0 <= px && px <= m[k].x1 &&
                m[k].y0 <= py && py <= m[k].y1 && !(m[k].blink && phase))
                return m[k].colour;
        end
        return (act && phase) ? FLASH : BG;
    endfunction

    // One clock: drive inputs, advance, compare, update model. When
    // use_model is 0 the fixed expectation exp_c is used instead.
    task automatic cycle(input string name, input int px, py, input bit ft, act, rs,
                         input bit we, input int idx, input logic [RW-1:0] wd,
                         input bit use_model, input logic [15:0] exp_c);
        logic [15:0] exp;
        x = 7'(px); y = 6'(py); frame_tick = ft; active = act; reset = rs;
        wr_bus.wr_en = we; wr_bus.wr_idx = 4'(idx); wr_bus.wr_data = wd;
        if (rs)             exp = BG;
        else if (use_model) exp = model_pixel(px, py, act);
        else                exp = exp_c;
        @(posedge clk);
        #1;
        if (rs) begin
            for (int k = 0; k < NR; k++) m[k] = '{0, 0, 0, 0, 16'h0, 1'b0, 1'b0};
            ticks = 0;
        end else begin
            if (we && idx < NR)
                m[idx] = '{int'(wd[43:37]), int'(wd[36:30]), int'(wd[29:24]),
                           int'(wd[23:18]), wd[17:2], wd[1], wd[0]};
            if (ft) ticks++;
        end
        check(name, oled_data, exp);
        wr_bus.wr_en = 1'b0; frame_tick = 1'b0; reset = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [RW-1:0] wd);
        cycle("write", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, idx, wd, 1'b1, 16'h0);
    endtask

    task automatic px(input string name, input int px_, py_, input bit act, input logic [15:0] e);
        cycle(name, px_, py_, 1'b0, act, 1'b0, 1'b0, 0, '0, 1'b0, e);
    endtask

    task automatic tick(input string name, input int px_, py_, input bit act, input logic [15:0] e);
        cycle(name, px_, py_, 1'b1, act, 1'b0, 1'b0, 0, '0, 1'b0, e);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"s0_corner_lo",  35, 11, 1'b0, 16'h8204};
        vecs[1] = '{"s0_right_out",  63, 11, 1'b0, 16'hFFFF};
        vecs[2] = '{"s0_corner_hi",  62, 22, 1'b0, 16'h8204};
        vecs[3] = '{"s0_left_out",   34, 11, 1'b0, 16'hFFFF};
        vecs[4] = '{"s0_below_out",  62, 23, 1'b0, 16'hFFFF};
        vecs[5] = '{"prio_s5_wins",  45, 36, 1'b0, 16'h07E0};
        vecs[6] = '{"s2_only",       31, 36, 1'b0, 16'h0000};
        vecs[7] = '{"s5_only",       50, 45, 1'b0, 16'h07E0};
        vecs[8] = '{"no_hit_bg",     60, 45, 1'b1, 16'hFFFF};

        x = '0; y = '0; frame_tick = 1'b0; active = 1'b0; reset = 1'b1;
        wr_bus.wr_en = 1'b0; wr_bus.wr_idx = '0; wr_bus.wr_data = '0;
        ticks = 0;

        // Reset state, including a write and tick held off by reset.
        cycle("reset_bg", 10, 10, 1'b1, 1'b1, 1'b1, 1'b1, 0, pack(0, 95, 0, 63, RED, 1, 0), 1'b0, BG);
        cycle("reset_bg2", 10, 10, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0, BG);
        px("post_reset_bg", 10, 10, 1'b0, 16'hFFFF);
        px("post_reset_no_flash", 10, 10, 1'b1, 16'hFFFF);

        // Basic rectangles and priority.
        wr(0, pack(35, 62, 11, 22, 16'h8204, 1, 0));
        wr(2, pack(30, 67, 35, 40, 16'h0000, 1, 0));
        wr(5, pack(40, 57, 35, 47, 16'h07E0, 1, 0));
        for (int i = 0; i < 9; i++) px(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].act, vecs[i].exp);

        // Out-of-range index and inverted bounds.
        wr(12, pack(0, 127, 0, 63, RED, 1, 0));
        px("idx12_ignored", 10, 10, 1'b0, 16'hFFFF);
        wr(3, pack(50, 40, 0, 63, BLUE, 1, 0));
        px("inverted_x_never", 45, 30, 1'b0, 16'hFFFF);
        px("inverted_x_edge", 50, 30, 1'b0, 16'hFFFF);

        // Write and lookup in the same cycle sees the old slot.
        cycle("wr_same_cycle_old", 5, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1,
              pack(0, 10, 0, 10, RED, 1, 1), 1'b0, 16'hFFFF);
        px("wr_next_cycle_new", 5, 5, 1'b1, RED);

        // Blinking with active=1.
        tick("blink_tick1", 5, 5, 1'b1, RED);
        tick("blink_tick2", 5, 5, 1'b1, RED);
        px("blink_hidden_flash", 5, 5, 1'b1, 16'hF81F);
        px("bg_flash", 80, 60, 1'b1, 16'hF81F);
        tick("blink_tick3", 5, 5, 1'b1, 16'hF81F);
        cycle("tick_with_write", 5, 5, 1'b1, 1'b1, 1'b0, 1'b1, 4,
              pack(90, 95, 60, 63, BLUE, 1, 0), 1'b0, 16'hF81F);
        px("blink_restored", 5, 5, 1'b1, RED);
        px("tick_write_slot4", 92, 61, 1'b1, BLUE);

        // Blinking with active=0.
        tick("inact_tick1", 5, 5, 1'b0, RED);
        tick("inact_tick2", 5, 5, 1'b0, RED);
        px("hidden_inactive_bg", 5, 5, 1'b0, 16'hFFFF);
        px("bg_inactive", 80, 60, 1'b0, 16'hFFFF);
        px("nonblink_slot_shown", 35, 11, 1'b1, 16'h8204);

        // Reset during blink_phase=1 with enabled slots.
        cycle("reset_mid_frame", 35, 11, 1'b1, 1'b1, 1'b1, 1'b1, 0,
              pack(0, 95, 0, 63, RED, 1, 0), 1'b0, 16'hFFFF);
        px("after_reset_s0_gone", 35, 11, 1'b1, 16'hFFFF);
        px("after_reset_s1_gone", 5, 5, 1'b1, 16'hFFFF);
        wr(1, pack(0, 10, 0, 10, RED, 1, 1));
        tick("after_reset_tick1", 5, 5, 1'b1, RED);
        px("phase_still_zero", 5, 5, 1'b1, RED);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit          rs, we, ft, act;
            int          idx;
            logic [RW-1:0] wd;
            rs  = ($urandom_range(0, 59) == 0);
            we  = ($urandom_range(0, 3) == 0);
            ft  = ($urandom_range(0, 2) == 0);
            act = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            wd  = pack($urandom_range(0, 100), $urandom_range(0, 100),
                       $urandom_range(0, 63), $urandom_range(0, 63),
                       16'($urandom), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)));
            cycle("random", $urandom_range(0, 127), $urandom_range(0, 63),
                  ft, act, rs, we, idx, wd, 1'b1, 16'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
